// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states,
// instruction geometry and the canonical NOP word.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Every instruction is one 32-bit word; the PC advances by this many bytes.
  localparam int INSTR_BYTES = 4;

  // Low address bits that must be zero for a word-aligned fetch address.
  localparam int                    ALIGN_BITS = 2;
  localparam logic [ALIGN_BITS-1:0] ALIGN_MASK = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when the low bits of an address would make it non-word-aligned.
  function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] low_bits);
    return (low_bits & ALIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with a synchronous clear; it sticks at all-ones
// instead of wrapping so long stalls never read back as short ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count up on inc, hold once every bit is set, clear has priority.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one request/grant/response memory
// transaction per instruction, holds the returned word for decode under a
// valid/ready handshake, and supplies the next value of the PC register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic [ADDR_W-1:0]  pc_write_value,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic               misalign_flag,
  output logic [CNT_W-1:0]   stall_cycles
);

  fetch_state_e       state_reg;
  logic               kill_reg;
  logic               hold_valid_reg;
  logic               misalign_reg;
  logic [ADDR_W-1:0]  req_pc_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic [INSTR_W-1:0] instr_reg;

  logic [ADDR_W-1:0]  redirect_aligned;
  logic [ADDR_W-1:0]  pc_plus4;
  logic               transfer;
  logic               kill_now;
  logic               stall_inc;

  // Redirect targets are forced onto a word boundary; the misalignment is
  // reported separately rather than faulting here.
  assign redirect_aligned = {redirect_target[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  // Wraps naturally at the top of the address space.
  assign pc_plus4         = pc_value + ADDR_W'(INSTR_BYTES);

  // A redirect in the same cycle as the response must squash it too.
  assign kill_now  = kill_reg || redirect_valid;
  assign transfer  = instr_valid && instr_ready;
  assign stall_inc = (state_reg == ST_WAIT) || ((state_reg == ST_HOLD) && !instr_ready);

  // Request is a pure decode of the state register, so it is glitch-free.
  assign imem_req  = (state_reg == ST_REQ);
  assign imem_addr = pc_value;

  // The held word is hidden from decode in the cycle a redirect squashes it.
  assign instr_valid   = hold_valid_reg && !redirect_valid;
  assign instr         = instr_reg;
  assign instr_pc      = instr_pc_reg;
  assign misalign_flag = misalign_reg;

  // Next-PC select: reset holds, redirect wins, a grant advances, else hold.
  always_comb begin
    pc_write_value = pc_value;
    if (rst) begin
      pc_write_value = pc_value;
    end else if (redirect_valid) begin
      pc_write_value = redirect_aligned;
    end else if ((state_reg == ST_REQ) && imem_gnt) begin
      pc_write_value = pc_plus4;
    end
  end

  // Fetch FSM with its registered datapath (held word, its PC, kill marker).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      kill_reg       <= 1'b0;
      hold_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      req_pc_reg     <= '0;
      instr_pc_reg   <= '0;
      instr_reg      <= '0;
    end else begin
      misalign_reg <= redirect_valid && is_misaligned(redirect_target[ALIGN_BITS-1:0]);
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            // The memory has committed; a concurrent redirect can only mark
            // the response for disposal.
            req_pc_reg <= pc_value;
            kill_reg   <= redirect_valid;
            state_reg  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            kill_reg <= 1'b0;
            if (kill_now) begin
              state_reg <= ST_REQ;
            end else begin
              instr_reg      <= imem_rdata;
              instr_pc_reg   <= req_pc_reg;
              hold_valid_reg <= 1'b1;
              state_reg      <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            kill_reg <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid || transfer) begin
            hold_valid_reg <= 1'b0;
            state_reg      <= ST_REQ;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. The bench plays the PC register and the
// instruction memory, keeps a transaction-level model of the fetch stage,
// and checks every DUT output against it on each falling clock edge.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int P_BOOT   = 0;
  localparam int P_ISSUE  = 1;
  localparam int P_FLIGHT = 2;
  localparam int P_HELD   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_value;
  logic [31:0] pc_write_value;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_flag;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc_value        (pc_value),
    .pc_write_value  (pc_write_value),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .misalign_flag   (misalign_flag),
    .stall_cycles    (stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: low byte 0x13, address shifted above it.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  // Values captured on the falling edge for the PC-register / memory emulation.
  logic [31:0] cap_pcw   = RESET_PC;
  logic        cap_grant = 1'b0;
  logic [31:0] cap_gaddr = '0;
  logic        cap_rst   = 1'b1;

  // Memory emulation state (touched only by the stimulus process).
  logic        gnt_en   = 1'b1;
  int          latency  = 0;
  logic        pending  = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;

  // Behavioural model of the fetch stage.
  logic        model_on = 1'b0;
  int          m_phase  = P_BOOT;
  logic        m_killed = 1'b0;
  logic [31:0] m_req_pc = '0;
  logic [31:0] m_instr  = '0;
  logic [31:0] m_ipc    = '0;
  logic        m_mis    = 1'b0;
  logic [15:0] m_stall  = '0;

  // Compare process: check outputs against the model, then advance the model
  // with the inputs the DUT will see at the coming rising edge.
  initial begin
    logic [31:0] exp_pcw;
    forever begin
      @(negedge clk);
      cap_pcw   = pc_write_value;
      cap_grant = imem_req && imem_gnt;
      cap_gaddr = imem_addr;
      cap_rst   = rst;

      if (rst) exp_pcw = pc_value;
      else if (redirect_valid) exp_pcw = {redirect_target[31:2], 2'b00};
      else if (m_phase == P_ISSUE && imem_gnt) exp_pcw = pc_value + 32'd4;
      else exp_pcw = pc_value;

      if (rst && !model_on) chk("pcw_in_reset", pc_write_value, pc_value);
      if (model_on) begin
        chk("cyc_pc_write", pc_write_value, exp_pcw);
        chk("cyc_imem_req", imem_req, m_phase == P_ISSUE);
        chk("cyc_imem_addr", imem_addr, pc_value);
        chk("cyc_instr_valid", instr_valid, (m_phase == P_HELD) && !redirect_valid);
        chk("cyc_instr", instr, m_instr);
        chk("cyc_instr_pc", instr_pc, m_ipc);
        chk("cyc_misalign", misalign_flag, m_mis);
        chk("cyc_stall", stall_cycles, m_stall);
      end

      if (rst) begin
        model_on = 1'b1;
        m_phase  = P_BOOT;
        m_killed = 1'b0;
        m_req_pc = '0;
        m_instr  = '0;
        m_ipc    = '0;
        m_mis    = 1'b0;
        m_stall  = '0;
      end else if (model_on) begin
        if ((m_phase == P_FLIGHT || (m_phase == P_HELD && !instr_ready)) && m_stall != 16'hFFFF)
          m_stall = m_stall + 16'd1;
        m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
        case (m_phase)
          P_BOOT: m_phase = P_ISSUE;
          P_ISSUE: if (imem_gnt) begin
            m_req_pc = pc_value;
            m_killed = redirect_valid;
            m_phase  = P_FLIGHT;
          end
          P_FLIGHT: begin
            if (imem_rvalid) begin
              if (m_killed || redirect_valid) begin
                m_phase = P_ISSUE;
              end else begin
                m_instr = imem_rdata;
                m_ipc   = m_req_pc;
                m_phase = P_HELD;
              end
              m_killed = 1'b0;
            end else if (redirect_valid) begin
              m_killed = 1'b1;
            end
          end
          default: if (redirect_valid || instr_ready) m_phase = P_ISSUE;
        endcase
      end
    end
  end

  // Advance one clock: update the emulated PC register and memory just after
  // the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (cap_rst) begin
      pending     = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pc_value    = RESET_PC;
    end else begin
      pc_value = cap_pcw;
      if (cap_grant) begin
        pending   = 1'b1;
        pend_addr = cap_gaddr;
        pend_cnt  = latency;
      end
      if (pending && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pending) pend_cnt--;
      end
    end
    imem_gnt = imem_req && gnt_en;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 40 && !instr_valid; k++) begin
      cycle();
      #1;
    end
    chk({name, "_valid_seen"}, instr_valid, 1'b1);
  endtask

  // Wait for the next request, checking that nothing reaches decode meanwhile.
  task automatic wait_req_no_valid(input string name);
    for (int k = 0; k < 40 && !imem_req; k++) begin
      cycle();
      #1;
      chk({name, "_no_valid"}, instr_valid, 1'b0);
    end
    chk({name, "_req_seen"}, imem_req, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    pc_value = RESET_PC;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b1;

    repeat (3) cycle();
    #1;
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_misalign", misalign_flag, 1'b0);
    chk("rst_stall", stall_cycles, 16'h0);

    // 1: first fetch from 0, zero-wait memory, decode ready.
    rst = 1'b0;
    cycle(); #1;
    chk("t1_req", imem_req, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_pcw_grant", pc_write_value, 32'h4);
    cycle(); #1;
    chk("t1_wait_no_req", imem_req, 1'b0);
    cycle(); #1;
    chk("t1_valid_cycle3", instr_valid, 1'b1);
    chk("t1_instr", instr, 32'h13);
    chk("t1_instr_pc", instr_pc, 32'h0);

    // 2: decode stalls five cycles in HOLD on the fetch from 4.
    cycle();
    instr_ready = 1'b0;
    wait_valid("t2");
    chk("t2_instr", instr, 32'h413);
    chk("t2_instr_pc", instr_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      cycle(); #1;
      chk("t2_hold_valid", instr_valid, 1'b1);
      chk("t2_instr_stable", instr, 32'h413);
      chk("t2_no_req", imem_req, 1'b0);
      chk("t2_pcw_hold", pc_write_value, 32'h8);
    end
    // one WAIT cycle per fetch so far (2) plus five HOLD stalls
    chk("t2_stall_count", stall_cycles, 16'd7);
    instr_ready = 1'b1;
    cycle(); #1;

    // 3: redirect to 0x100 while waiting on a slow response.
    latency = 2;
    chk("t3_req_at_8", imem_addr, 32'h8);
    cycle(); #1;
    chk("t3_in_wait", imem_req, 1'b0);
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    wait_req_no_valid("t3");
    chk("t3_new_addr", imem_addr, 32'h100);
    wait_valid("t3");
    chk("t3_instr_pc", instr_pc, 32'h100);
    chk("t3_instr", instr, 32'h10013);

    // 4: misaligned redirect in HOLD with ready high in the same cycle.
    redirect_valid = 1'b1;
    redirect_target = 32'h202;
    instr_ready = 1'b1;
    #1;
    chk("t4_valid_masked", instr_valid, 1'b0);
    chk("t4_pcw_aligned", pc_write_value, 32'h200);
    chk("t4_mis_before", misalign_flag, 1'b0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t4_mis_pulse", misalign_flag, 1'b1);
    chk("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 32'h200);
    latency = 0;
    cycle(); #1;
    chk("t4_mis_cleared", misalign_flag, 1'b0);
    wait_valid("t4");
    chk("t4_instr_pc", instr_pc, 32'h200);

    // 5a: redirect while the request waits for a grant.
    gnt_en = 1'b0;
    cycle(); #1;
    chk("t5_req_nogrant", imem_req, 1'b1);
    chk("t5_addr_204", imem_addr, 32'h204);
    chk("t5_pcw_nogrant", pc_write_value, 32'h204);
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    #1;
    chk("t5_pcw_redir", pc_write_value, 32'h300);
    cycle();
    redirect_valid = 1'b0;
    gnt_en = 1'b1;
    #1;
    chk("t5_addr_300", imem_addr, 32'h300);
    // 5b: redirect to the last word together with a grant.
    cycle();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    #1;
    chk("t5_granted", imem_gnt, 1'b1);
    chk("t5_pcw_priority", pc_write_value, 32'hFFFF_FFFC);
    cycle();
    redirect_valid = 1'b0;
    wait_req_no_valid("t5");
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t5_pcw_wrap", pc_write_value, 32'h0);
    wait_valid("t5");
    chk("t5_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("t5_instr", instr, 32'hFFFF_FC13);
    cycle(); #1;
    chk("t5_wrapped_addr", imem_addr, 32'h0);

    // 6: reset while a response is outstanding, then a stray late rvalid.
    latency = 3;
    cycle(); #1;
    chk("t6_in_wait", imem_req, 1'b0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_valid_low", instr_valid, 1'b0);
    chk("t6_stall_clear", stall_cycles, 16'h0);
    chk("t6_idle_no_req", imem_req, 1'b0);
    chk("t6_instr_clear", instr, 32'h0);
    latency = 0;
    cycle();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_req_after_rst", imem_req, 1'b1);
    chk("t6_addr_after_rst", imem_addr, RESET_PC);
    wait_valid("t6");
    chk("t6_instr", instr, 32'h13);
    chk("t6_instr_pc", instr_pc, 32'h0);

    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
